hazard_ctrl: RTL and testbench

Decode-stage hazard and sequencing controller for the 5-stage pipeline. It sits between the main `control` decoder and the ID/EX register. It owns the ID/EX control bundle (`wb`/`mem`/`ex`), detects load-use hazards, and injects a single bubble while freezing PC and IF/ID. It also squashes younger instructions when a BEQ resolves taken in MEM, and keeps a saturating bubble count for performance checks.

---
 rtl/pipe_ctrl_pkg.sv | 43 ++++
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline control definitions: opcodes, ID/EX bundle layout,
// hazard controller state encoding and operand-usage helpers.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_NOP   = 6'b100000;

   localparam int REGWRITE = 1;
   localparam int MEMTOREG = 0;
   localparam int BRANCH   = 2;
   localparam int MEMREAD  = 1;
   localparam int MEMWRITE = 0;
   localparam int REGDST   = 3;
   localparam int ALUOP_HI = 2;
   localparam int ALUOP_LO = 1;
   localparam int ALUSRC   = 0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      BR_FLUSH = 2'd2
   } state_e;

   typedef struct packed {
      logic [1:0] wb;
      logic [2:0] mem;
      logic [3:0] ex;
   } id_ex_t;

   function automatic logic reads_rs(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) ||
             (op == OP_SW)    || (op == OP_BEQ);
   endfunction

   // LW names rt as its destination, so it never depends on it
   function automatic logic reads_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: owns the ID/EX control bundle, stalls
// one cycle on load-use, squashes younger work on a taken BEQ.
module hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic [1:0]       wb_in,
   input  logic [2:0]       mem_in,
   input  logic [3:0]       ex_in,
   input  logic             branch_taken,
   output logic [1:0]       wb_q,
   output logic [2:0]       mem_q,
   output logic [3:0]       ex_q,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             exmem_flush,
   output logic [CNT_W-1:0] bubble_cnt
);

   state_e     state_q;
   logic [4:0] id_ex_rt_q;
   logic       br;
   logic       rs_hit;
   logic       rt_hit;
   logic       load_use;
   logic       bubble;

   assign br = branch_taken & ~rst;

   assign rs_hit = reads_rs(opcode) && (ifid_rs == id_ex_rt_q);
   assign rt_hit = reads_rt(opcode) && (ifid_rt == id_ex_rt_q);

   // $0 is hardwired, so a load targeting it never creates a dependency
   assign load_use = ~rst
                   && (state_q == RUN)
                   && mem_q[MEMREAD]
                   && (id_ex_rt_q != 5'd0)
                   && (rs_hit || rt_hit);

   assign bubble = br | load_use;

   // A taken branch squashes the stalled instruction, so no freeze
   assign pc_write    = ~(load_use & ~br);
   assign ifid_write  = ~(load_use & ~br);
   assign ifid_flush  = br;
   assign exmem_flush = br;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         wb_q       <= '0;
         mem_q      <= '0;
         ex_q       <= '0;
         id_ex_rt_q <= '0;
      end else begin
         id_ex_rt_q <= ifid_rt;
         if (bubble) begin
            wb_q  <= '0;
            mem_q <= '0;
            ex_q  <= '0;
         end else begin
            wb_q  <= wb_in;
            mem_q <= mem_in;
            ex_q  <= ex_in;
         end
         unique case (state_q)
            RUN: begin
               if (br) begin
                  state_q <= BR_FLUSH;
               end else if (load_use) begin
                  state_q <= LU_STALL;
               end else begin
                  state_q <= RUN;
               end
            end
            LU_STALL: begin
               state_q <= br ? BR_FLUSH : RUN;
            end
            BR_FLUSH: begin
               state_q <= RUN;
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_bubble_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (bubble),
      .clr  (1'b0),
      .count(bubble_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a 2-bit bubble counter so that
// saturation is reachable in a handful of stalls.
module tb_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int CW = 2;

   localparam logic [8:0] C_RT  = 9'b10_000_1100;
   localparam logic [8:0] C_LW  = 9'b11_010_0001;
   localparam logic [8:0] C_SW  = 9'b00_001_0001;
   localparam logic [8:0] C_BEQ = 9'b00_100_0010;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    opcode;
   logic [4:0]    ifid_rs;
   logic [4:0]    ifid_rt;
   logic [1:0]    wb_in;
   logic [2:0]    mem_in;
   logic [3:0]    ex_in;
   logic          branch_taken;
   logic [1:0]    wb_q;
   logic [2:0]    mem_q;
   logic [3:0]    ex_q;
   logic          pc_write;
   logic          ifid_write;
   logic          ifid_flush;
   logic          exmem_flush;
   logic [CW-1:0] bubble_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .ifid_rs     (ifid_rs),
      .ifid_rt     (ifid_rt),
      .wb_in       (wb_in),
      .mem_in      (mem_in),
      .ex_in       (ex_in),
      .branch_taken(branch_taken),
      .wb_q        (wb_q),
      .mem_q       (mem_q),
      .ex_q        (ex_q),
      .pc_write    (pc_write),
      .ifid_write  (ifid_write),
      .ifid_flush  (ifid_flush),
      .exmem_flush (exmem_flush),
      .bubble_cnt  (bubble_cnt)
   );

   function automatic logic [8:0] ctl(input logic [5:0] op);
      case (op)
         OP_RTYPE: return C_RT;
         OP_LW:    return C_LW;
         OP_SW:    return C_SW;
         OP_BEQ:   return C_BEQ;
         default:  return 9'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one IF/ID instruction, check comb controls, then clock it
   task automatic step(input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic bt,
                       input logic exp_pw, input logic exp_fl,
                       input string tag);
      logic [8:0] c;
      c = ctl(op);
      opcode       = op;
      ifid_rs      = rs;
      ifid_rt      = rt;
      wb_in        = c[8:7];
      mem_in       = c[6:4];
      ex_in        = c[3:0];
      branch_taken = bt;
      #1;
      chk({tag, ".pc_write"},    32'(pc_write),    32'(exp_pw));
      chk({tag, ".ifid_write"},  32'(ifid_write),  32'(exp_pw));
      chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(exp_fl));
      chk({tag, ".exmem_flush"}, 32'(exmem_flush), 32'(exp_fl));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_q(input string tag, input logic [8:0] exp_b,
                        input int exp_cnt, input state_e exp_st);
      chk({tag, ".bundle"}, 32'({wb_q, mem_q, ex_q}), 32'(exp_b));
      chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(exp_cnt));
      chk({tag, ".state"}, 32'(dut.state_q), 32'(exp_st));
   endtask

   initial begin
      rst = 1'b1;
      @(negedge clk);
      step(OP_NOP, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, "rst_a");
      step(OP_RTYPE, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, "rst_b");
      step(OP_LW, 5'd1, 5'd8, 1'b1, 1'b1, 1'b0, "rst_c");
      chk_q("reset", 9'd0, 0, RUN);
      rst = 1'b0;

      step(OP_LW, 5'd1, 5'd8, 1'b0, 1'b1, 1'b0, "lu_lw");
      chk_q("lu_lw", C_LW, 0, RUN);
      step(OP_RTYPE, 5'd8, 5'd2, 1'b0, 1'b0, 1'b0, "lu_stall");
      chk_q("lu_bubble", 9'd0, 1, LU_STALL);
      step(OP_RTYPE, 5'd8, 5'd2, 1'b0, 1'b1, 1'b0, "lu_reissue");
      chk_q("lu_issue", C_RT, 1, RUN);

      step(OP_LW, 5'd1, 5'd8, 1'b0, 1'b1, 1'b0, "lwrt_a");
      step(OP_LW, 5'd9, 5'd8, 1'b0, 1'b1, 1'b0, "lwrt_b");
      chk_q("lwrt", C_LW, 1, RUN);
      step(OP_NOP, 5'd8, 5'd8, 1'b0, 1'b1, 1'b0, "nop_nodep");
      chk_q("nop_nodep", 9'd0, 1, RUN);

      step(OP_LW, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0, "r0_lw");
      step(OP_RTYPE, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, "r0_use");
      chk_q("r0", C_RT, 1, RUN);

      step(OP_RTYPE, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, "br");
      chk_q("br", 9'd0, 2, BR_FLUSH);
      step(OP_RTYPE, 5'd3, 5'd4, 1'b0, 1'b1, 1'b0, "br_after");
      chk_q("br_after", C_RT, 2, RUN);

      step(OP_LW, 5'd1, 5'd8, 1'b0, 1'b1, 1'b0, "brlu_lw");
      step(OP_RTYPE, 5'd8, 5'd2, 1'b1, 1'b1, 1'b1, "brlu");
      chk_q("brlu", 9'd0, 3, BR_FLUSH);
      step(OP_NOP, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, "brlu_after");
      chk_q("brlu_after", 9'd0, 3, RUN);

      rst = 1'b1;
      step(OP_NOP, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, "rst2");
      rst = 1'b0;
      chk_q("rst2", 9'd0, 0, RUN);

      step(OP_LW, 5'd1, 5'd8, 1'b0, 1'b1, 1'b0, "b2b_lw1");
      step(OP_LW, 5'd8, 5'd9, 1'b0, 1'b0, 1'b0, "b2b_lw2_stall");
      chk_q("b2b_s1", 9'd0, 1, LU_STALL);
      step(OP_LW, 5'd8, 5'd9, 1'b0, 1'b1, 1'b0, "b2b_lw2_go");
      chk_q("b2b_lw2", C_LW, 1, RUN);
      step(OP_RTYPE, 5'd9, 5'd3, 1'b0, 1'b0, 1'b0, "b2b_add_stall");
      chk_q("b2b_s2", 9'd0, 2, LU_STALL);
      step(OP_RTYPE, 5'd9, 5'd3, 1'b0, 1'b1, 1'b0, "b2b_add_go");
      chk_q("b2b_add", C_RT, 2, RUN);

      step(OP_LW, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, "sw_lw");
      step(OP_SW, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, "sw_stall");
      chk_q("sw_s", 9'd0, 3, LU_STALL);
      step(OP_SW, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, "sw_go");
      chk_q("sw_go", C_SW, 3, RUN);

      step(OP_LW, 5'd1, 5'd6, 1'b0, 1'b1, 1'b0, "beq_lw");
      step(OP_BEQ, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0, "beq_stall");
      chk_q("sat_a", 9'd0, 3, LU_STALL);
      step(OP_BEQ, 5'd2, 5'd6, 1'b0, 1'b1, 1'b0, "beq_go");
      chk_q("beq_go", C_BEQ, 3, RUN);

      step(OP_LW, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, "sat_lw");
      step(OP_RTYPE, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, "sat_stall");
      chk_q("sat_b", 9'd0, 3, LU_STALL);

      rst = 1'b1;
      step(OP_RTYPE, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, "rst_stall");
      chk_q("rst_stall", 9'd0, 0, RUN);
      rst = 1'b0;
      step(OP_RTYPE, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, "post_rst");
      chk_q("post_rst", C_RT, 0, RUN);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
